// File: rtl/branch_unit_mp_pkg.sv
// Shared types for the branch unit.
//   bru_subtype_e       : BRU instruction subtypes (JMP / BNZ / BEZ)
//   BRU_VALID_SUBTYPES  : bit vector indexed by subtype, 1 = legal encoding
//   br_class_e          : divergence class reported to the fetcher
package branch_unit_mp_pkg;

  typedef enum logic [1:0] {
    BRU_JMP = 2'd0,
    BRU_BNZ = 2'd1,
    BRU_BEZ = 2'd2
  } bru_subtype_e;

  localparam logic [3:0] BRU_VALID_SUBTYPES = 4'b0111;

  typedef enum logic [1:0] {
    BR_UNIFORM_TAKEN = 2'd0,
    BR_UNIFORM_FALL  = 2'd1,
    BR_DIVERGENT     = 2'd2
  } br_class_e;

  function automatic logic bru_sub_valid(input bru_subtype_e s);
    return BRU_VALID_SUBTYPES[s];
  endfunction

endpackage

// File: rtl/branch_unit_mp_if.sv
// Bus bundle of the branch unit: operand-collector intake, result-collector
// output and fetcher branch-event output.
//   slave  : the branch unit side
//   master : the surrounding compute unit (or testbench)
interface branch_unit_mp_if #(
  parameter int WarpWidth       = 4,
  parameter int RegWidth        = 32,
  parameter int OperandsPerInst = 2,
  parameter int RegIdxWidth     = 8,
  parameter int PcWidth         = 16,
  parameter int IidWidth        = 6,
  parameter int WidWidth        = 3
) ();
  import branch_unit_mp_pkg::*;

  // operand collector -> unit
  logic                                     eu_to_opc_ready_o;
  logic                                     opc_to_eu_valid_i;
  logic [WarpWidth-1:0]                     opc_to_eu_act_mask_i;
  logic [IidWidth-1:0]                      opc_to_eu_tag_i;
  logic [PcWidth-1:0]                       opc_to_eu_pc_i;
  bru_subtype_e                             opc_to_eu_inst_sub_i;
  logic [RegIdxWidth-1:0]                   opc_to_eu_dst_i;
  logic [OperandsPerInst*WarpWidth*RegWidth-1:0] opc_to_eu_operands_i;
  // unit -> result collector
  logic                                     rc_to_eu_ready_i;
  logic                                     eu_to_rc_valid_o;
  logic [WarpWidth-1:0]                     eu_to_rc_act_mask_o;
  logic [IidWidth-1:0]                      eu_to_rc_tag_o;
  logic [RegIdxWidth-1:0]                   eu_to_rc_dst_o;
  logic [WarpWidth*RegWidth-1:0]            eu_to_rc_data_o;
  // unit -> fetcher
  logic                                     fe_to_bru_ready_i;
  logic                                     bru_to_fe_valid_o;
  logic [WidWidth-1:0]                      bru_to_fe_wid_o;
  logic [WarpWidth-1:0]                     bru_to_fe_taken_mask_o;
  logic [WarpWidth-1:0]                     bru_to_fe_fall_mask_o;
  br_class_e                                bru_to_fe_class_o;
  logic [PcWidth-1:0]                       bru_to_fe_target_pc_o;
  logic [PcWidth-1:0]                       bru_to_fe_fall_pc_o;

  modport slave (
    output eu_to_opc_ready_o,
    input  opc_to_eu_valid_i, opc_to_eu_act_mask_i, opc_to_eu_tag_i, opc_to_eu_pc_i,
    input  opc_to_eu_inst_sub_i, opc_to_eu_dst_i, opc_to_eu_operands_i,
    input  rc_to_eu_ready_i,
    output eu_to_rc_valid_o, eu_to_rc_act_mask_o, eu_to_rc_tag_o, eu_to_rc_dst_o, eu_to_rc_data_o,
    input  fe_to_bru_ready_i,
    output bru_to_fe_valid_o, bru_to_fe_wid_o, bru_to_fe_taken_mask_o, bru_to_fe_fall_mask_o,
    output bru_to_fe_class_o, bru_to_fe_target_pc_o, bru_to_fe_fall_pc_o
  );

  modport master (
    input  eu_to_opc_ready_o,
    output opc_to_eu_valid_i, opc_to_eu_act_mask_i, opc_to_eu_tag_i, opc_to_eu_pc_i,
    output opc_to_eu_inst_sub_i, opc_to_eu_dst_i, opc_to_eu_operands_i,
    output rc_to_eu_ready_i,
    input  eu_to_rc_valid_o, eu_to_rc_act_mask_o, eu_to_rc_tag_o, eu_to_rc_dst_o, eu_to_rc_data_o,
    output fe_to_bru_ready_i,
    input  bru_to_fe_valid_o, bru_to_fe_wid_o, bru_to_fe_taken_mask_o, bru_to_fe_fall_mask_o,
    input  bru_to_fe_class_o, bru_to_fe_target_pc_o, bru_to_fe_fall_pc_o
  );

endinterface

// File: rtl/branch_unit_mp_fifo.sv
// bru_event_fifo: Depth-entry FIFO of type T with valid/ready read side.
//   clk_i, rst_i : clock, synchronous active-high reset
//   push_i/data_i: write strobe and entry (caller only pushes when it may)
//   full_o       : no free entry (a same-cycle pop still frees one)
//   valid_o/ready_i/data_o : head entry handshake; data_o is 0 when empty
module bru_event_fifo #(
  parameter type T     = logic [7:0],
  parameter int  Depth = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     data_i,
  output logic full_o,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  T                mem_q [Depth];
  logic [PtrW-1:0] wr_q, rd_q, wr_d, rd_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pop;

  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign pop     = valid_o && ready_i;
  assign data_o  = valid_o ? mem_q[rd_q] : '0;

  // explicit wrap so non-power-of-two depths work
  assign wr_d = (wr_q == PtrW'(Depth - 1)) ? '0 : wr_q + PtrW'(1);
  assign rd_d = (rd_q == PtrW'(Depth - 1)) ? '0 : rd_q + PtrW'(1);

  always_comb begin
    cnt_d = cnt_q;
    case ({push_i, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_d;
      if (pop)    rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

`ifndef SYNTHESIS
  logic stall_q;
  T     prev_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= 1'b0;
      prev_q  <= '0;
    end else begin
      assert (!(push_i && full_o && !pop))
        else $error("bru_event_fifo: push into full FIFO");
      if (stall_q)
        assert (valid_o && data_o == prev_q)
          else $error("bru_event_fifo: head changed while stalled");
      stall_q <= valid_o && !ready_i;
      prev_q  <= data_o;
    end
  end
`endif

endmodule

// File: rtl/branch_unit_mp.sv
// branch_unit_mp: branch execution unit.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : instruction intake, per-thread result/link output through
//                  a NumStages valid/ready pipeline, and branch events to the
//                  fetcher through a BrqDepth-entry FIFO (1-cycle latency).
module branch_unit_mp
  import branch_unit_mp_pkg::*;
#(
  parameter int NumTags         = 8,
  parameter int RegWidth        = 32,
  parameter int WarpWidth       = 4,
  parameter int NumWarps        = 8,
  parameter int OperandsPerInst = 2,
  parameter int RegIdxWidth     = 8,
  parameter int PcWidth         = 16,
  parameter int NumStages       = 1,
  parameter int BrqDepth        = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  branch_unit_mp_if.slave  bus
);
  localparam int TagWidth = $clog2(NumTags);
  localparam int WidWidth = (NumWarps > 1) ? $clog2(NumWarps) : 1;
  localparam int IidWidth = TagWidth + WidWidth;

  typedef logic [IidWidth-1:0]           iid_t;
  typedef logic [PcWidth-1:0]            pc_t;
  typedef logic [WarpWidth-1:0]          act_mask_t;
  typedef logic [WidWidth-1:0]           wid_t;
  typedef logic [RegIdxWidth-1:0]        reg_idx_t;
  typedef logic [WarpWidth*RegWidth-1:0] warp_data_t;

  typedef struct packed {
    wid_t      wid;
    act_mask_t taken;
    act_mask_t fall;
    br_class_e cls;
    pc_t       target;
    pc_t       fall_pc;
  } br_event_t;

  typedef struct packed {
    act_mask_t  mask;
    iid_t       tag;
    reg_idx_t   dst;
    warp_data_t data;
  } rc_pl_t;

  // ---------------- decode / evaluate ----------------
  act_mask_t  act, cond, taken, fall;
  pc_t        pc_inc, target;
  br_class_e  cls;
  warp_data_t res_data;
  logic       unused_ops;

  assign act    = bus.opc_to_eu_act_mask_i;
  assign pc_inc = bus.opc_to_eu_pc_i + pc_t'(1);
  // only op0 low bits and op1 are consumed
  assign unused_ops = ^bus.opc_to_eu_operands_i;

  always_comb begin
    cond     = '0;
    res_data = '0;
    target   = pc_inc;
    for (int i = 0; i < WarpWidth; i++) begin
      case (bus.opc_to_eu_inst_sub_i)
        BRU_JMP: begin
          cond[i] = 1'b1;
          res_data[i*RegWidth +: RegWidth] = RegWidth'(pc_inc);
        end
        BRU_BNZ: begin
          cond[i] = (bus.opc_to_eu_operands_i[(WarpWidth+i)*RegWidth +: RegWidth] != '0);
          res_data[i*RegWidth +: RegWidth] = RegWidth'(cond[i]);
        end
        BRU_BEZ: begin
          cond[i] = (bus.opc_to_eu_operands_i[(WarpWidth+i)*RegWidth +: RegWidth] == '0);
          res_data[i*RegWidth +: RegWidth] = RegWidth'(cond[i]);
        end
        default: begin
          cond[i] = 1'b0;
          res_data[i*RegWidth +: RegWidth] = '1;
        end
      endcase
    end
    // descending scan so the lowest active lane wins
    for (int i = WarpWidth - 1; i >= 0; i--)
      if (act[i]) target = bus.opc_to_eu_operands_i[i*RegWidth +: PcWidth];
  end

  assign taken = act & cond;
  assign fall  = act & ~cond;

  always_comb begin
    if (act == '0)          cls = BR_UNIFORM_FALL;
    else if (taken == act)  cls = BR_UNIFORM_TAKEN;
    else if (taken == '0)   cls = BR_UNIFORM_FALL;
    else                    cls = BR_DIVERGENT;
  end

  // ---------------- intake ----------------
  logic [NumStages:0] rdy;
  logic               brq_full, brq_pop, in_rdy, accept;
  br_event_t          ev_in, ev_out;

  // FIFO term applies to every subtype since every subtype emits an event
  assign in_rdy  = rdy[0] && (!brq_full || brq_pop);
  assign accept  = bus.opc_to_eu_valid_i && in_rdy;
  assign brq_pop = bus.bru_to_fe_valid_o && bus.fe_to_bru_ready_i;
  assign bus.eu_to_opc_ready_o = in_rdy;

  // ---------------- result pipeline ----------------
  logic [NumStages-1:0] vld_q;
  rc_pl_t               pl_q [NumStages];
  rc_pl_t               pl_in;

  assign pl_in = '{mask: act, tag: bus.opc_to_eu_tag_i, dst: bus.opc_to_eu_dst_i,
                   data: res_data};
  assign rdy[NumStages] = bus.rc_to_eu_ready_i;

  for (genvar s = 0; s < NumStages; s++) begin : g_stage
    logic   in_v;
    rc_pl_t in_pl;
    if (s == 0) begin : g_head
      assign in_v  = accept;
      assign in_pl = pl_in;
    end else begin : g_link
      assign in_v  = vld_q[s-1];
      assign in_pl = pl_q[s-1];
    end

    assign rdy[s] = !vld_q[s] || rdy[s+1];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        vld_q[s] <= 1'b0;
        pl_q[s]  <= '0;
      end else if (rdy[s]) begin
        vld_q[s] <= in_v;
        if (in_v) pl_q[s] <= in_pl;
      end
    end
  end

  assign bus.eu_to_rc_valid_o    = vld_q[NumStages-1];
  assign bus.eu_to_rc_act_mask_o = pl_q[NumStages-1].mask;
  assign bus.eu_to_rc_tag_o      = pl_q[NumStages-1].tag;
  assign bus.eu_to_rc_dst_o      = pl_q[NumStages-1].dst;
  assign bus.eu_to_rc_data_o     = pl_q[NumStages-1].data;

  // ---------------- branch-event queue ----------------
  assign ev_in = '{wid: bus.opc_to_eu_tag_i[WidWidth-1:0], taken: taken, fall: fall,
                   cls: cls, target: target, fall_pc: pc_inc};

  bru_event_fifo #(.T(br_event_t), .Depth(BrqDepth)) u_brq (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .data_i  (ev_in),
    .full_o  (brq_full),
    .valid_o (bus.bru_to_fe_valid_o),
    .ready_i (bus.fe_to_bru_ready_i),
    .data_o  (ev_out)
  );

  assign bus.bru_to_fe_wid_o        = ev_out.wid;
  assign bus.bru_to_fe_taken_mask_o = ev_out.taken;
  assign bus.bru_to_fe_fall_mask_o  = ev_out.fall;
  assign bus.bru_to_fe_class_o      = ev_out.cls;
  assign bus.bru_to_fe_target_pc_o  = ev_out.target;
  assign bus.bru_to_fe_fall_pc_o    = ev_out.fall_pc;

`ifndef SYNTHESIS
  logic   rc_stall_q;
  rc_pl_t rc_prev_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rc_stall_q <= 1'b0;
      rc_prev_q  <= '0;
    end else begin
      if (bus.opc_to_eu_valid_i)
        assert (bru_sub_valid(bus.opc_to_eu_inst_sub_i))
          else $error("branch_unit_mp: invalid BRU subtype");
      if (rc_stall_q)
        assert (vld_q[NumStages-1] && pl_q[NumStages-1] == rc_prev_q)
          else $error("branch_unit_mp: result changed while stalled");
      rc_stall_q <= vld_q[NumStages-1] && !bus.rc_to_eu_ready_i;
      rc_prev_q  <= pl_q[NumStages-1];
    end
  end
`endif

endmodule

// File: tb/tb_branch_unit_mp.sv
module tb_branch_unit_mp;
  import branch_unit_mp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  branch_unit_mp_if #(
    .WarpWidth(4), .RegWidth(32), .OperandsPerInst(2), .RegIdxWidth(8),
    .PcWidth(16), .IidWidth(6), .WidWidth(3)
  ) bif ();

  branch_unit_mp #(.NumStages(3), .BrqDepth(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bif)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bru_subtype_e sub, input logic [3:0] act, input logic [5:0] tag,
                       input logic [15:0] pc, input logic [7:0] dst,
                       input logic [31:0] a0, a1, a2, a3, b0, b1, b2, b3);
    bif.opc_to_eu_valid_i    = 1'b1;
    bif.opc_to_eu_inst_sub_i = sub;
    bif.opc_to_eu_act_mask_i = act;
    bif.opc_to_eu_tag_i      = tag;
    bif.opc_to_eu_pc_i       = pc;
    bif.opc_to_eu_dst_i      = dst;
    bif.opc_to_eu_operands_i = {b3, b2, b1, b0, a3, a2, a1, a0};
  endtask

  task automatic chk_event(input string n, input logic [2:0] wid, input logic [3:0] tk,
                           input logic [3:0] fl, input br_class_e c,
                           input logic [15:0] tgt, input logic [15:0] fpc);
    chk({n, "_fe_valid"}, bif.bru_to_fe_valid_o, 1'b1);
    chk({n, "_wid"},      bif.bru_to_fe_wid_o, wid);
    chk({n, "_taken"},    bif.bru_to_fe_taken_mask_o, tk);
    chk({n, "_fall"},     bif.bru_to_fe_fall_mask_o, fl);
    chk({n, "_class"},    bif.bru_to_fe_class_o, c);
    chk({n, "_target"},   bif.bru_to_fe_target_pc_o, tgt);
    chk({n, "_fall_pc"},  bif.bru_to_fe_fall_pc_o, fpc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  t5_tags [4];
    logic        stalled_prev, accepted;
    logic [5:0]  prev_tag;
    logic [7:0]  prev_dst;
    int          sent, got;

    bif.opc_to_eu_valid_i    = 1'b0;
    bif.opc_to_eu_act_mask_i = '0;
    bif.opc_to_eu_tag_i      = '0;
    bif.opc_to_eu_pc_i       = '0;
    bif.opc_to_eu_inst_sub_i = BRU_JMP;
    bif.opc_to_eu_dst_i      = '0;
    bif.opc_to_eu_operands_i = '0;
    bif.rc_to_eu_ready_i     = 1'b1;
    bif.fe_to_bru_ready_i    = 1'b1;

    // ---- reset state ----
    tick(); tick();
    @(negedge clk);
    chk("rst_rc_valid", bif.eu_to_rc_valid_o, 1'b0);
    chk("rst_fe_valid", bif.bru_to_fe_valid_o, 1'b0);
    chk("rst_rc_data",  bif.eu_to_rc_data_o, 128'h0);
    chk("rst_fe_target", bif.bru_to_fe_target_pc_o, 16'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", bif.eu_to_opc_ready_o, 1'b1);

    // ---- T1: BNZ divergent ----
    tick();
    drive(BRU_BNZ, 4'b1111, 6'b101011, 16'h0010, 8'h05,
          32'h40, 32'h50, 32'h60, 32'h70, 32'd0, 32'd5, 32'd0, 32'd7);
    @(negedge clk);
    chk("t1_ready", bif.eu_to_opc_ready_o, 1'b1);
    tick();
    bif.opc_to_eu_valid_i = 1'b0;
    @(negedge clk);
    chk_event("t1", 3'd3, 4'b1010, 4'b0101, BR_DIVERGENT, 16'h0040, 16'h0011);
    chk("t1_rc_early0", bif.eu_to_rc_valid_o, 1'b0);
    tick();
    @(negedge clk);
    chk("t1_rc_early1", bif.eu_to_rc_valid_o, 1'b0);
    chk("t1_fe_popped", bif.bru_to_fe_valid_o, 1'b0);
    tick();
    @(negedge clk);
    chk("t1_rc_valid", bif.eu_to_rc_valid_o, 1'b1);
    chk("t1_rc_data",  bif.eu_to_rc_data_o, {32'd1, 32'd0, 32'd1, 32'd0});
    chk("t1_rc_tag",   bif.eu_to_rc_tag_o, 6'b101011);
    chk("t1_rc_dst",   bif.eu_to_rc_dst_o, 8'h05);
    chk("t1_rc_mask",  bif.eu_to_rc_act_mask_o, 4'b1111);
    tick();

    // ---- T2: BEZ, partial mask, uniform taken ----
    drive(BRU_BEZ, 4'b0110, 6'h0C, 16'h0020, 8'h06,
          32'h99, 32'h22, 32'h33, 32'h44, 32'd0, 32'd0, 32'd0, 32'd0);
    tick();
    bif.opc_to_eu_valid_i = 1'b0;
    @(negedge clk);
    chk_event("t2", 3'd4, 4'b0110, 4'b0000, BR_UNIFORM_TAKEN, 16'h0022, 16'h0021);
    tick(); tick();
    @(negedge clk);
    chk("t2_rc_data", bif.eu_to_rc_data_o, {32'd1, 32'd1, 32'd1, 32'd1});
    chk("t2_rc_mask", bif.eu_to_rc_act_mask_o, 4'b0110);
    tick();

    // ---- T3: JMP at PC wrap ----
    drive(BRU_JMP, 4'b1111, 6'h01, 16'hFFFF, 8'h07,
          32'h1234, 32'h5, 32'h6, 32'h7, 32'd9, 32'd9, 32'd9, 32'd9);
    tick();
    bif.opc_to_eu_valid_i = 1'b0;
    @(negedge clk);
    chk_event("t3", 3'd1, 4'b1111, 4'b0000, BR_UNIFORM_TAKEN, 16'h1234, 16'h0000);
    tick(); tick();
    @(negedge clk);
    chk("t3_rc_link", bif.eu_to_rc_data_o, 128'h0);
    tick();

    // ---- T3b: empty active mask -> uniform fall, target = pc+1 ----
    drive(BRU_BNZ, 4'b0000, 6'h02, 16'h0030, 8'h08,
          32'h55, 32'h56, 32'h57, 32'h58, 32'd1, 32'd1, 32'd1, 32'd1);
    tick();
    bif.opc_to_eu_valid_i = 1'b0;
    @(negedge clk);
    chk_event("t3b", 3'd2, 4'b0000, 4'b0000, BR_UNIFORM_FALL, 16'h0031, 16'h0031);
    tick();

    // ---- T3c: all active fall through ----
    drive(BRU_BNZ, 4'b1111, 6'h05, 16'h0040, 8'h09,
          32'h77, 32'h78, 32'h79, 32'h7A, 32'd0, 32'd0, 32'd0, 32'd0);
    tick();
    bif.opc_to_eu_valid_i = 1'b0;
    @(negedge clk);
    chk_event("t3c", 3'd5, 4'b0000, 4'b1111, BR_UNIFORM_FALL, 16'h0077, 16'h0041);
    tick(); tick(); tick();

    // ---- T4: full FIFO, push+pop on full ----
    bif.fe_to_bru_ready_i = 1'b0;
    drive(BRU_BNZ, 4'b1111, 6'h11, 16'h0100, 8'h01, 32'h1, 32'h1, 32'h1, 32'h1,
          32'd1, 32'd1, 32'd1, 32'd1);
    @(negedge clk);
    chk("t4_rdy_a", bif.eu_to_opc_ready_o, 1'b1);
    tick();
    drive(BRU_BNZ, 4'b1111, 6'h12, 16'h0200, 8'h02, 32'h2, 32'h2, 32'h2, 32'h2,
          32'd1, 32'd1, 32'd1, 32'd1);
    @(negedge clk);
    chk("t4_rdy_b", bif.eu_to_opc_ready_o, 1'b1);
    tick();
    drive(BRU_BNZ, 4'b1111, 6'h13, 16'h0300, 8'h03, 32'h3, 32'h3, 32'h3, 32'h3,
          32'd1, 32'd1, 32'd1, 32'd1);
    @(negedge clk);
    chk("t4_rdy_full", bif.eu_to_opc_ready_o, 1'b0);
    tick();
    bif.fe_to_bru_ready_i = 1'b1;
    @(negedge clk);
    chk("t4_rdy_pushpop", bif.eu_to_opc_ready_o, 1'b1);
    chk("t4_head_a", bif.bru_to_fe_wid_o, 3'd1);
    tick();
    bif.opc_to_eu_valid_i = 1'b0;
    bif.fe_to_bru_ready_i = 1'b0;
    @(negedge clk);
    chk("t4_head_b_valid", bif.bru_to_fe_valid_o, 1'b1);
    chk("t4_head_b", bif.bru_to_fe_wid_o, 3'd2);
    chk("t4_still_full", bif.eu_to_opc_ready_o, 1'b0);
    bif.fe_to_bru_ready_i = 1'b1;
    tick();
    @(negedge clk);
    chk("t4_head_c", bif.bru_to_fe_wid_o, 3'd3);
    chk("t4_head_c_pc", bif.bru_to_fe_fall_pc_o, 16'h0301);
    tick();
    @(negedge clk);
    chk("t4_drained", bif.bru_to_fe_valid_o, 1'b0);
    tick(); tick();

    // ---- T5: result backpressure during a 4-instruction burst ----
    t5_tags = '{6'h20, 6'h21, 6'h22, 6'h23};
    sent = 0;
    got = 0;
    stalled_prev = 1'b0;
    prev_tag = '0;
    prev_dst = '0;
    bif.rc_to_eu_ready_i = 1'b0;
    for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
      if (cyc == 5) bif.rc_to_eu_ready_i = 1'b1;
      if (sent < 4)
        drive(BRU_BNZ, 4'b1111, t5_tags[sent], 16'h0500, 8'(8'h10 + sent),
              32'h0, 32'h0, 32'h0, 32'h0, 32'd1, 32'd0, 32'd1, 32'd0);
      else
        bif.opc_to_eu_valid_i = 1'b0;
      @(negedge clk);
      if (cyc == 3) chk("t5_stall_ready", bif.eu_to_opc_ready_o, 1'b0);
      if (stalled_prev) begin
        chk("t5_stable_tag", bif.eu_to_rc_tag_o, prev_tag);
        chk("t5_stable_dst", bif.eu_to_rc_dst_o, prev_dst);
      end
      if (bif.eu_to_rc_valid_o && bif.rc_to_eu_ready_i) begin
        chk("t5_order_tag", bif.eu_to_rc_tag_o, t5_tags[got]);
        chk("t5_order_dst", bif.eu_to_rc_dst_o, 8'(8'h10 + got));
        got++;
      end
      accepted     = bif.opc_to_eu_valid_i && bif.eu_to_opc_ready_o;
      stalled_prev = bif.eu_to_rc_valid_o && !bif.rc_to_eu_ready_i;
      prev_tag     = bif.eu_to_rc_tag_o;
      prev_dst     = bif.eu_to_rc_dst_o;
      tick();
      if (accepted) sent++;
    end
    bif.opc_to_eu_valid_i = 1'b0;
    chk("t5_all_delivered", 32'(got), 32'd4);
    tick(); tick();

    // ---- T6: reset mid-operation ----
    bif.rc_to_eu_ready_i  = 1'b0;
    bif.fe_to_bru_ready_i = 1'b1;
    drive(BRU_JMP, 4'b1111, 6'h31, 16'h0600, 8'h21, 32'h0, 32'h0, 32'h0, 32'h0,
          32'd0, 32'd0, 32'd0, 32'd0);
    tick();
    drive(BRU_JMP, 4'b1111, 6'h32, 16'h0700, 8'h22, 32'h0, 32'h0, 32'h0, 32'h0,
          32'd0, 32'd0, 32'd0, 32'd0);
    tick();
    bif.opc_to_eu_valid_i = 1'b0;
    bif.fe_to_bru_ready_i = 1'b0;
    @(negedge clk);
    chk("t6_event_inflight", bif.bru_to_fe_valid_o, 1'b1);
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("t6_rc_dropped", bif.eu_to_rc_valid_o, 1'b0);
    chk("t6_fe_dropped", bif.bru_to_fe_valid_o, 1'b0);
    chk("t6_rc_tag_zero", bif.eu_to_rc_tag_o, 6'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_ready", bif.eu_to_opc_ready_o, 1'b1);
    bif.rc_to_eu_ready_i  = 1'b1;
    bif.fe_to_bru_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      @(negedge clk);
      chk("t6_no_stale_rc", bif.eu_to_rc_valid_o, 1'b0);
      chk("t6_no_stale_fe", bif.bru_to_fe_valid_o, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
